// File: rtl/lq_mem_scheduler.sv
// lq_mem_scheduler: per-entry memory-access tracking for load-queue entries
// that missed store forwarding. Shares NUM_PORT dcache load ports among
// NUM_LD entries round-robin, retries rejected requests, waits for tagged
// refills on misses, and holds the returned word until the entry is cleared.
//
// state | meaning
// IDLE  | entry has no outstanding memory access
// PEND  | entry wants a cache port; re-arbitrates every cycle until accepted
// WAIT  | cache accepted a miss; waiting for a refill tagged with this entry
// DONE  | data captured; done_valid high until the entry is cleared
module lq_mem_scheduler #(
  parameter int NUM_LD     = 4,
  parameter int NUM_PORT   = 2,
  parameter int NUM_REFILL = 2,
  parameter int IDX_W      = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_LD-1:0]           ld_req_valid,
  input  logic [NUM_LD*32-1:0]        ld_req_addr,
  input  logic [NUM_LD*3-1:0]         ld_req_func,
  input  logic [NUM_LD-1:0]           ld_clear,
  output logic [NUM_PORT-1:0]         port_valid,
  output logic [NUM_PORT*IDX_W-1:0]   port_idx,
  output logic [NUM_PORT*32-1:0]      port_addr,
  output logic [NUM_PORT*3-1:0]       port_func,
  input  logic [NUM_PORT-1:0]         port_accept,
  input  logic [NUM_PORT-1:0]         port_hit,
  input  logic [NUM_PORT*32-1:0]      port_data,
  input  logic [NUM_REFILL-1:0]       refill_valid,
  input  logic [NUM_REFILL*IDX_W-1:0] refill_idx,
  input  logic [NUM_REFILL*32-1:0]    refill_data,
  output logic [NUM_LD-1:0]           done_valid,
  output logic [NUM_LD*32-1:0]        done_data,
  output logic [NUM_LD*2-1:0]         pend_state
);

  localparam int PW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } ld_state_e;

  ld_state_e        state_q [NUM_LD];
  ld_state_e        state_d [NUM_LD];
  logic [31:0]      data_q  [NUM_LD];
  logic [31:0]      data_d  [NUM_LD];
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;

  logic [NUM_LD-1:0] granted;
  logic [PW-1:0]     gnt_port [NUM_LD];

  // Round-robin scan of PEND entries from rr_ptr; k-th hit drives port k.
  // Depends only on state and entry fields, never on port_accept.
  always_comb begin
    int cnt;
    int j;
    port_valid = '0;
    port_idx   = '0;
    port_addr  = '0;
    port_func  = '0;
    granted    = '0;
    rr_ptr_d   = rr_ptr_q;
    cnt        = 0;
    j          = 0;
    for (int i = 0; i < NUM_LD; i++) begin
      gnt_port[i] = '0;
    end
    for (int o = 0; o < NUM_LD; o++) begin
      j = (int'(rr_ptr_q) + o) % NUM_LD;
      if (state_q[j] == S_PEND && cnt < NUM_PORT) begin
        port_valid[cnt]                 = 1'b1;
        port_idx[cnt*IDX_W +: IDX_W]    = IDX_W'(j);
        port_addr[cnt*32 +: 32]         = ld_req_addr[j*32 +: 32];
        port_func[cnt*3 +: 3]           = ld_req_func[j*3 +: 3];
        granted[j]                      = 1'b1;
        gnt_port[j]                     = PW'(cnt);
        // Last assignment wins: pointer moves past the highest port's entry.
        rr_ptr_d                        = IDX_W'((j + 1) % NUM_LD);
        cnt                             = cnt + 1;
      end
    end
  end

  // Per-entry next state and data capture; clear overrides everything else.
  always_comb begin
    for (int i = 0; i < NUM_LD; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (ld_req_valid[i]) state_d[i] = S_PEND;
        end
        S_PEND: begin
          if (granted[i] && port_accept[gnt_port[i]]) begin
            if (port_hit[gnt_port[i]]) begin
              state_d[i] = S_DONE;
              data_d[i]  = port_data[gnt_port[i]*32 +: 32];
            end else begin
              state_d[i] = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Descending scan so the lowest matching channel is applied last.
          for (int r = NUM_REFILL - 1; r >= 0; r--) begin
            if (refill_valid[r] && refill_idx[r*IDX_W +: IDX_W] == IDX_W'(i)) begin
              state_d[i] = S_DONE;
              data_d[i]  = refill_data[r*32 +: 32];
            end
          end
        end
        default: ;
      endcase
      if (ld_clear[i]) begin
        state_d[i] = S_IDLE;
        data_d[i]  = data_q[i];
      end
    end
  end

  // Observable entry status, straight from the state and data registers.
  always_comb begin
    done_valid = '0;
    done_data  = '0;
    pend_state = '0;
    for (int i = 0; i < NUM_LD; i++) begin
      done_valid[i]          = (state_q[i] == S_DONE);
      done_data[i*32 +: 32]  = data_q[i];
      pend_state[i*2 +: 2]   = state_q[i];
    end
  end

  // State, data and round-robin pointer registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LD; i++) begin
        state_q[i] <= S_IDLE;
        data_q[i]  <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LD; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_lq_mem_scheduler.sv
// Bench for lq_mem_scheduler: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural model of the entry rules.
module tb_lq_mem_scheduler;
  localparam int NL = 4;
  localparam int NP = 2;
  localparam int NR = 2;
  localparam int IW = 2;

  logic              clock;
  logic              reset;
  logic [NL-1:0]     ld_req_valid;
  logic [NL*32-1:0]  ld_req_addr;
  logic [NL*3-1:0]   ld_req_func;
  logic [NL-1:0]     ld_clear;
  logic [NP-1:0]     port_valid;
  logic [NP*IW-1:0]  port_idx;
  logic [NP*32-1:0]  port_addr;
  logic [NP*3-1:0]   port_func;
  logic [NP-1:0]     port_accept;
  logic [NP-1:0]     port_hit;
  logic [NP*32-1:0]  port_data;
  logic [NR-1:0]     refill_valid;
  logic [NR*IW-1:0]  refill_idx;
  logic [NR*32-1:0]  refill_data;
  logic [NL-1:0]     done_valid;
  logic [NL*32-1:0]  done_data;
  logic [NL*2-1:0]   pend_state;

  lq_mem_scheduler #(.NUM_LD(NL), .NUM_PORT(NP), .NUM_REFILL(NR), .IDX_W(IW)) dut (
    .clock(clock), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_func(ld_req_func),
    .ld_clear(ld_clear),
    .port_valid(port_valid), .port_idx(port_idx), .port_addr(port_addr), .port_func(port_func),
    .port_accept(port_accept), .port_hit(port_hit), .port_data(port_data),
    .refill_valid(refill_valid), .refill_idx(refill_idx), .refill_data(refill_data),
    .done_valid(done_valid), .done_data(done_data), .pend_state(pend_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  // Model: entry state 0=IDLE 1=PEND 2=WAIT 3=DONE, captured words, rr pointer.
  int          m_st   [NL];
  logic [31:0] m_data [NL];
  int          m_rr;
  int          g_ent  [NP];
  int          g_n;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk entries from the rr pointer, first NP pending ones get ports.
  function automatic void model_grant();
    int q[$];
    q = {};
    for (int o = 0; o < NL; o++)
      if (m_st[(m_rr + o) % NL] == 1) q.push_back((m_rr + o) % NL);
    g_n = (q.size() < NP) ? q.size() : NP;
    for (int k = 0; k < g_n; k++) g_ent[k] = q[k];
  endfunction

  task automatic compare_all();
    logic [NP-1:0]    ev;
    logic [NL*2-1:0]  es;
    logic [NL-1:0]    edv;
    logic [NL*32-1:0] edd;
    model_grant();
    ev = '0;
    for (int k = 0; k < g_n; k++) ev[k] = 1'b1;
    check("port_valid", 128'(port_valid), 128'(ev));
    for (int k = 0; k < g_n; k++) begin
      check("port_idx",  128'(port_idx[k*IW +: IW]),  128'(g_ent[k]));
      check("port_addr", 128'(port_addr[k*32 +: 32]), 128'(ld_req_addr[g_ent[k]*32 +: 32]));
      check("port_func", 128'(port_func[k*3 +: 3]),   128'(ld_req_func[g_ent[k]*3 +: 3]));
    end
    for (int i = 0; i < NL; i++) begin
      es[i*2 +: 2]   = 2'(m_st[i]);
      edv[i]         = (m_st[i] == 3);
      edd[i*32 +: 32] = m_data[i];
    end
    check("pend_state", 128'(pend_state), 128'(es));
    check("done_valid", 128'(done_valid), 128'(edv));
    check("done_data",  128'(done_data),  128'(edd));
  endtask

  function automatic void model_step();
    int          ns [NL];
    logic [31:0] nd [NL];
    if (!reset) begin
      for (int i = 0; i < NL; i++) begin m_st[i] = 0; m_data[i] = '0; end
      m_rr = 0;
      return;
    end
    model_grant();
    for (int i = 0; i < NL; i++) begin ns[i] = m_st[i]; nd[i] = m_data[i]; end
    for (int k = 0; k < g_n; k++) begin
      if (port_accept[k]) begin
        if (port_hit[k]) begin ns[g_ent[k]] = 3; nd[g_ent[k]] = port_data[k*32 +: 32]; end
        else ns[g_ent[k]] = 2;
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (m_st[i] == 0 && ld_req_valid[i]) ns[i] = 1;
      if (m_st[i] == 2) begin
        for (int r = 0; r < NR; r++) begin
          if (refill_valid[r] && int'(refill_idx[r*IW +: IW]) == i) begin
            ns[i] = 3; nd[i] = refill_data[r*32 +: 32];
            break;
          end
        end
      end
      if (ld_clear[i]) begin ns[i] = 0; nd[i] = m_data[i]; end
    end
    if (g_n > 0) m_rr = (g_ent[g_n-1] + 1) % NL;
    for (int i = 0; i < NL; i++) begin m_st[i] = ns[i]; m_data[i] = nd[i]; end
  endfunction

  // Inputs are set at a negedge; check settled outputs, advance the model, cross the posedge.
  task automatic cyc(input bit chk = 1'b1);
    #1;
    if (chk) compare_all();
    model_step();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; ld_req_valid = '0; ld_clear = '0;
    port_accept = '0; port_hit = '0; port_data = '0;
    refill_valid = '0; refill_idx = '0; refill_data = '0;
    for (int i = 0; i < NL; i++) begin
      ld_req_addr[i*32 +: 32] = 32'h100 * (i + 1);
      ld_req_func[i*3 +: 3]   = 3'(i);
    end
    m_rr = 0;
    for (int i = 0; i < NL; i++) begin m_st[i] = 0; m_data[i] = '0; end
    @(negedge clock);

    // Reset held with all requests asserted
    ld_req_valid = 4'hF;
    cyc(1'b0);
    cyc();
    check("rst_port_valid", 128'(port_valid), 128'(0));
    check("rst_pend_state", 128'(pend_state), 128'(0));
    reset = 1'b1;
    cyc();
    check("rel_port_valid", 128'(port_valid), 128'(2'b11));
    check("rel_port_idx",   128'(port_idx),   128'(4'b0100));
    check("rel_port_addr",  128'(port_addr),  128'(64'h00000200_00000100));
    ld_req_valid = '0; ld_clear = 4'hF;
    cyc();
    ld_clear = '0;

    // Hit path on entry 2
    ld_req_addr[2*32 +: 32] = 32'h1000; ld_req_func[2*3 +: 3] = 3'b010;
    ld_req_valid = 4'b0100;
    cyc();
    ld_req_valid = '0;
    check("hit_port_idx", 128'(port_idx[IW-1:0]), 128'(2));
    port_accept = 2'b01; port_hit = 2'b01; port_data = 64'h0_DEADBEEF;
    cyc();
    port_accept = '0; port_hit = '0;
    check("hit_done_valid", 128'(done_valid[2]), 128'(1));
    check("hit_done_data",  128'(done_data[2*32 +: 32]), 128'(32'hDEADBEEF));
    ld_clear = 4'b0100;
    cyc();
    ld_clear = '0;
    check("hit_cleared", 128'(pend_state[5:4]), 128'(0));

    // Miss on entry 1, refill three cycles later on channel 1
    ld_req_addr[1*32 +: 32] = 32'h2000;
    ld_req_valid = 4'b0010;
    cyc();
    ld_req_valid = '0;
    port_accept = 2'b01;
    cyc();
    port_accept = '0;
    check("miss_wait", 128'(pend_state[3:2]), 128'(2));
    cyc();
    cyc();
    refill_valid = 2'b10; refill_idx = 4'b0100; refill_data = 64'h12345678_00000000;
    cyc();
    check("refill_done_valid", 128'(done_valid[1]), 128'(1));
    check("refill_done_data",  128'(done_data[1*32 +: 32]), 128'(32'h12345678));
    refill_valid = 2'b01; refill_idx = 4'b0011; refill_data = 64'h0_00000BAD;
    cyc();
    refill_valid = '0;
    check("refill_idle_ignored", 128'(pend_state[7:6]), 128'(0));
    check("refill_done_kept", 128'(done_data[1*32 +: 32]), 128'(32'h12345678));
    ld_clear = 4'b0010;
    cyc();
    ld_clear = '0;

    // Fairness with persistent rejects
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    ld_req_valid = 4'hF;
    cyc();
    ld_req_valid = '0;
    check("rr_grant0", 128'(port_idx), 128'(4'b0100));
    cyc();
    check("rr_grant1", 128'(port_idx), 128'(4'b1110));
    cyc();
    check("rr_grant2", 128'(port_idx), 128'(4'b0100));
    cyc();

    // Clear collisions: entry 3 hit+clear, then entry 0 refill+clear
    port_accept = 2'b10; port_hit = 2'b10; port_data = 64'hCAFEF00D_00000000; ld_clear = 4'b1000;
    cyc();
    port_accept = '0; port_hit = '0; ld_clear = '0;
    check("clr_hit_state", 128'(pend_state[7:6]), 128'(0));
    check("clr_hit_data",  128'(done_data[3*32 +: 32]), 128'(0));
    port_accept = 2'b01;
    cyc();
    port_accept = '0;
    check("clr_wait0", 128'(pend_state[1:0]), 128'(2));
    refill_valid = 2'b01; refill_idx = 4'b0000; refill_data = 64'h0_55AA55AA; ld_clear = 4'b0001;
    cyc();
    refill_valid = '0; ld_clear = '0;
    check("clr_refill_valid", 128'(done_valid[0]), 128'(0));
    check("clr_refill_state", 128'(pend_state[1:0]), 128'(0));

    // Reset mid-operation with PEND/WAIT/DONE entries
    port_accept = 2'b11; port_hit = 2'b10; port_data = 64'h0BADCAFE_00000000; ld_req_valid = 4'b0001;
    cyc();
    port_accept = '0; port_hit = '0; ld_req_valid = '0;
    check("mid_states", 128'(pend_state), 128'(8'b00_10_11_01));
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    refill_valid = 2'b01; refill_idx = 4'b0010; refill_data = 64'h0_00000077;
    check("mid_rst_state", 128'(pend_state), 128'(0));
    check("mid_rst_done",  128'(done_valid), 128'(0));
    cyc();
    refill_valid = '0;
    check("mid_refill_ignored", 128'(pend_state), 128'(0));
    ld_req_valid = 4'hF;
    cyc();
    ld_req_valid = '0;
    check("mid_rr_zero", 128'(port_idx), 128'(4'b0100));

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < NL; i++) begin
        if (m_st[i] == 0) begin
          ld_req_addr[i*32 +: 32] = $urandom;
          ld_req_func[i*3 +: 3]   = 3'($urandom_range(0, 7));
        end
        ld_req_valid[i] = ($urandom_range(0, 2) == 0);
        ld_clear[i]     = ($urandom_range(0, 7) == 0);
      end
      port_accept  = 2'($urandom);
      port_hit     = 2'($urandom);
      port_data    = {$urandom, $urandom};
      refill_valid = 2'($urandom);
      refill_idx   = 4'($urandom);
      refill_data  = {$urandom, $urandom};
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
